proc_program_feeder: RTL



---
 rtl/proc_program_feeder.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/proc_program_feeder.sv
`default_nettype none
// ============================================================================
// Module      : proc_program_feeder
// Description : Fetches instruction/immediate words from a synchronous program
//               ROM and issues them to the 9-bit bus processor, one per Done.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_program_feeder #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [8:0]        rom_data,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic              Busy,
    output logic              Halted,
    output logic              Error,
    output logic [ADDR_W-1:0] pc,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [2:0] c_OP_MVI  = 3'b001;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    // Wide enough to hold TIMEOUT itself, reached when Done wins on the last cycle.
    localparam int               c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH_I = 4'd1,
        S_LOAD_I  = 4'd2,
        S_FETCH_D = 4'd3,
        S_LOAD_D  = 4'd4,
        S_ISSUE   = 4'd5,
        S_IMM     = 4'd6,
        S_WAIT    = 4'd7,
        S_HALT    = 4'd8,
        S_ERROR   = 4'd9
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [8:0]          r_instr;
    logic [8:0]          w_instr_nxt;
    logic [8:0]          r_imm;
    logic [8:0]          r_din;
    logic [8:0]          w_din_nxt;
    logic                r_run;
    logic                r_busy;
    logic                r_halted;
    logic                r_error;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_WD_W-1:0]   r_wd;
    logic                w_restart;
    logic                w_rom_is_mvi;
    logic                w_rom_is_halt;
    logic                w_q_is_mvi;

    assign w_rom_is_mvi  = (rom_data[8:6] == c_OP_MVI);
    assign w_rom_is_halt = (rom_data[8:6] == c_OP_HALT);
    assign w_q_is_mvi    = (r_instr[8:6] == c_OP_MVI);
    assign w_instr_nxt   = (r_state == S_LOAD_I) ? rom_data : r_instr;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_restart   = 1'b0;
        case (r_state)
            S_IDLE, S_HALT, S_ERROR: begin
                if (Start) begin
                    w_restart   = 1'b1;
                    w_pc_nxt    = '0;
                    w_state_nxt = S_FETCH_I;
                end
            end
            S_FETCH_I: w_state_nxt = S_LOAD_I;
            S_LOAD_I: begin
                if (w_rom_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_pc_nxt    = r_pc + 1'b1;
                    w_state_nxt = w_rom_is_mvi ? S_FETCH_D : S_ISSUE;
                end
            end
            S_FETCH_D: w_state_nxt = S_LOAD_D;
            S_LOAD_D: begin
                w_pc_nxt    = r_pc + 1'b1;
                w_state_nxt = S_ISSUE;
            end
            // Done during ISSUE belongs to the previous instruction and is ignored.
            S_ISSUE: w_state_nxt = w_q_is_mvi ? S_IMM : S_WAIT;
            S_IMM:   w_state_nxt = Done ? S_FETCH_I : S_WAIT;
            S_WAIT: begin
                if (Done) begin
                    w_state_nxt = S_FETCH_I;
                end else if (r_wd == c_WD_LAST) begin
                    w_state_nxt = S_ERROR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they hold for the whole state.
    always_comb begin
        w_din_nxt = '0;
        case (w_state_nxt)
            S_ISSUE: w_din_nxt = w_instr_nxt;
            S_IMM:   w_din_nxt = r_imm;
            S_WAIT:  w_din_nxt = w_q_is_mvi ? r_imm : 9'd0;
            default: w_din_nxt = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_rom_addr <= '0;
            r_instr    <= '0;
            r_imm      <= '0;
            r_din      <= '0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
            r_wd       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_din   <= w_din_nxt;
            r_run   <= (w_state_nxt == S_ISSUE);
            r_busy  <= !((w_state_nxt == S_IDLE) || (w_state_nxt == S_HALT) ||
                         (w_state_nxt == S_ERROR));

            if ((w_state_nxt == S_FETCH_I) || (w_state_nxt == S_FETCH_D)) begin
                r_rom_addr <= w_pc_nxt;
            end

            if (r_state == S_LOAD_D) begin
                r_imm <= rom_data;
            end

            if (w_restart) begin
                r_halted <= 1'b0;
            end else if ((r_state == S_LOAD_I) && w_rom_is_halt) begin
                r_halted <= 1'b1;
            end

            if (w_restart) begin
                r_error <= 1'b0;
            end else if (w_state_nxt == S_ERROR) begin
                r_error <= 1'b1;
            end

            if (w_restart) begin
                r_cnt <= '0;
            end else if ((w_state_nxt == S_ISSUE) && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_ISSUE) begin
                r_wd <= '0;
            end else if (r_state == S_WAIT) begin
                r_wd <= r_wd + 1'b1;
            end
        end
    end

    assign rom_addr    = r_rom_addr;
    assign DIN         = r_din;
    assign Run         = r_run;
    assign Busy        = r_busy;
    assign Halted      = r_halted;
    assign Error       = r_error;
    assign pc          = r_pc;
    assign instr_count = r_cnt;

endmodule
`default_nettype wire
